region_hit_tracker: RTL and testbench
=====================================

Name: region_hit_tracker

Overview:
- Pipelined, multi-channel successor to the single 1-D offset check: tests a streamed (x, y) coordinate against N_REGIONS programmable 2-D rectangles each cycle.
- Each rectangle is defined by a low corner (x, y) and a delta (dx, dy).
- Produces a per-region hit vector, a priority index and sticky hit flags.
- Sits between the pixel/grid scanner and the collision/render logic of the game.
- Region config is double-buffered so updates take effect only at frame boundaries.

Parameters:
- WIDTH, 16, coordinate and delta width in bits.
- N_REGIONS, 4, number of rectangles (>=2).
- IDX_W, $clog2(N_REGIONS), derived index width (localparam, not overridable).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write region shadow entry this cycle.
- cfg_idx  in  IDX_W  region being written.
- cfg_en  in  1  region enable bit for written entry.
- cfg_low_x, cfg_low_y  in  WIDTH  low corner.
- cfg_dx, cfg_dy  in  WIDTH  extent (inclusive: high = low + delta).
- frame_start  in  1  copy shadow config to active config.
- px_valid  in  1  coordinate qualifier.
- px_x, px_y  in  WIDTH  coordinate under test.
- sticky_clear  in  1  clear sticky flags.
- hit_valid  out  1  px_valid delayed 2 cycles.
- hit_vec  out  N_REGIONS  per-region containment, bit i = region i.
- hit_any  out  1  OR of hit_vec.
- hit_idx  out  IDX_W  lowest-numbered hitting region; 0 when hit_any=0.
- sticky_hits  out  N_REGIONS  accumulated hits since last clear.

Behaviour:
- Reset (async, reset_n=0): all shadow and active entries cleared (en=0, all fields 0). All pipeline registers and all outputs 0.
- Config write:
  - On a clock edge with cfg_we=1, shadow[cfg_idx] <= {cfg_en, low_x, low_y, dx, dy}.
  - cfg_idx >= N_REGIONS is ignored.
- Frame boundary: on a clock edge with frame_start=1, active[i] <= shadow[i] for all i.
- Simultaneous cfg_we and frame_start: active takes the pre-edge shadow value; the write lands in shadow only and becomes active at the next frame_start.
- Containment for region i (combinational on active config):
  - en && x_low <= px_x <= x_high && y_low <= px_y <= y_high.
  - high = low + delta, computed in WIDTH+1 bits and saturated to 2^WIDTH-1 (no wrap-around, unlike the prior block).
  - delta=0 means a single-coordinate-wide column or row.
- Pipeline stage 1 (edge after input):
  - Register px_valid into v1.
  - Register raw containment bits into c1, forced to 0 when px_valid=0.
- Pipeline stage 2 (next edge):
  - hit_valid <= v1, hit_vec <= c1, hit_any <= |c1.
  - hit_idx <= priority encode of c1 (lowest index wins).
- Latency: exactly 2 cycles from px_valid/px_x/px_y to outputs. Throughput 1 coordinate per cycle, no stalls.
- Config change latency: the compare in stage 1 uses the active config at the cycle of input sampling. A frame_start edge affects coordinates sampled on the following cycle.
- When hit_valid=0, hit_vec, hit_any and hit_idx are 0.
- Sticky flags, updated every edge:
  - sticky_hits <= (sticky_clear ? 0 : sticky_hits) | (hit_valid ? hit_vec : 0).
  - When clear and a hit coincide, the new hit is retained.
- frame_start does not clear sticky flags.
- Reset mid-frame: pipeline contents discarded. Config is lost; software must rewrite and pulse frame_start.

Decomposition:
- Package region_pkg:
  - DEFAULT_WIDTH=16, DEFAULT_N_REGIONS=4.
  - Function sat_add(low, delta) returning the saturated high.
  - Typedef region_cfg_t (en, low_x, low_y, dx, dy) sized from DEFAULT_WIDTH.
  - The top uses explicit per-field arrays when WIDTH is overridden.
- Sub-module region_cmp (parameter WIDTH): combinational 2-D saturated offset check for one region; instantiated N_REGIONS times via generate.
- Priority encoder inline in the top.

Test Plan:
1. Reset, write region0 {en=1, low=(10,20), d=(5,5)}, pulse frame_start, drive px=(15,25) valid. Required two cycles later: hit_valid=1, hit_vec=0001, hit_idx=0, sticky_hits=0001 one cycle after that.
2. Edges: px=(10,20) and (15,25) hit; px=(9,20), (16,25), (15,26) miss. Each result appears exactly 2 cycles after its input, with back-to-back valid inputs.
3. Saturation: region1 {low=(0xFFF0,0), d=(0x0020,0xFFFF)}, px=(0xFFFF,0x8000) -> hit. px=(0x0005,0x8000) -> miss (no wrap).
4. Overlap: region0 and region2 both contain (12,22) -> hit_vec=0101, hit_idx=0. Disable region0 via shadow write + frame_start -> hit_vec=0100, hit_idx=2.
5. Double buffering: write region3 and assert frame_start on the same edge. px inside region3 -> no hit. After the next frame_start -> hit_vec bit3=1.
6. Sticky: accumulate hits 0001 then 0100 -> sticky=0101. sticky_clear on the same cycle as hit_valid with hit_vec=0010 -> sticky=0010. Assert reset_n=0 mid-stream, asynchronously -> all outputs 0 immediately.

Source files
------------

// File: rtl/region_pkg.sv
// Shared defaults, the region config record and the saturating corner adder
// used by the rectangle hit tracker.
package region_pkg;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_N_REGIONS = 4;

  typedef struct packed {
    logic                     en;
    logic [DEFAULT_WIDTH-1:0] low_x;
    logic [DEFAULT_WIDTH-1:0] low_y;
    logic [DEFAULT_WIDTH-1:0] dx;
    logic [DEFAULT_WIDTH-1:0] dy;
  } region_cfg_t;

  // High corner = low + delta, clamped at all-ones instead of wrapping.
  function automatic logic [DEFAULT_WIDTH-1:0] sat_add(
    input logic [DEFAULT_WIDTH-1:0] low,
    input logic [DEFAULT_WIDTH-1:0] delta
  );
    logic [DEFAULT_WIDTH:0] sum;
    sum = {1'b0, low} + {1'b0, delta};
    return sum[DEFAULT_WIDTH] ? {DEFAULT_WIDTH{1'b1}} : sum[DEFAULT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/region_cmp.sv
// Combinational containment test of one coordinate against one rectangle
// whose inclusive high corner is low + delta, saturated at the top of the range.
module region_cmp
  import region_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             en,
  input  logic [WIDTH-1:0] low_x,
  input  logic [WIDTH-1:0] low_y,
  input  logic [WIDTH-1:0] dx,
  input  logic [WIDTH-1:0] dy,
  input  logic [WIDTH-1:0] px_x,
  input  logic [WIDTH-1:0] px_y,
  output logic             hit
);

  logic [WIDTH-1:0] high_x;
  logic [WIDTH-1:0] high_y;

  generate
    if (WIDTH == DEFAULT_WIDTH) begin : g_pkg_sat
      assign high_x = sat_add(low_x, dx);
      assign high_y = sat_add(low_y, dy);
    end else begin : g_local_sat
      // Overridden width: same clamp, sized locally.
      logic [WIDTH:0] sum_x;
      logic [WIDTH:0] sum_y;
      assign sum_x  = {1'b0, low_x} + {1'b0, dx};
      assign sum_y  = {1'b0, low_y} + {1'b0, dy};
      assign high_x = sum_x[WIDTH] ? {WIDTH{1'b1}} : sum_x[WIDTH-1:0];
      assign high_y = sum_y[WIDTH] ? {WIDTH{1'b1}} : sum_y[WIDTH-1:0];
    end
  endgenerate

  assign hit = en
            && (px_x >= low_x) && (px_x <= high_x)
            && (px_y >= low_y) && (px_y <= high_y);

endmodule

// File: rtl/region_hit_tracker.sv
// Two-stage pipelined test of a streamed (x, y) against N programmable
// rectangles with frame-synchronous double-buffered config and sticky hit flags.
module region_hit_tracker
  import region_pkg::*;
#(
  parameter  int WIDTH     = DEFAULT_WIDTH,
  parameter  int N_REGIONS = DEFAULT_N_REGIONS,
  localparam int IDX_W     = $clog2(N_REGIONS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic                 cfg_en,
  input  logic [WIDTH-1:0]     cfg_low_x,
  input  logic [WIDTH-1:0]     cfg_low_y,
  input  logic [WIDTH-1:0]     cfg_dx,
  input  logic [WIDTH-1:0]     cfg_dy,
  input  logic                 frame_start,
  input  logic                 px_valid,
  input  logic [WIDTH-1:0]     px_x,
  input  logic [WIDTH-1:0]     px_y,
  input  logic                 sticky_clear,
  output logic                 hit_valid,
  output logic [N_REGIONS-1:0] hit_vec,
  output logic                 hit_any,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [N_REGIONS-1:0] sticky_hits
);

  logic             shadow_en_reg    [N_REGIONS];
  logic [WIDTH-1:0] shadow_low_x_reg [N_REGIONS];
  logic [WIDTH-1:0] shadow_low_y_reg [N_REGIONS];
  logic [WIDTH-1:0] shadow_dx_reg    [N_REGIONS];
  logic [WIDTH-1:0] shadow_dy_reg    [N_REGIONS];

  logic             active_en_reg    [N_REGIONS];
  logic [WIDTH-1:0] active_low_x_reg [N_REGIONS];
  logic [WIDTH-1:0] active_low_y_reg [N_REGIONS];
  logic [WIDTH-1:0] active_dx_reg    [N_REGIONS];
  logic [WIDTH-1:0] active_dy_reg    [N_REGIONS];

  logic [N_REGIONS-1:0] raw_hit;
  logic                 v1_reg;
  logic [N_REGIONS-1:0] c1_reg;
  logic [IDX_W-1:0]     idx_next;

  // Active copies the pre-edge shadow, so a write on a frame_start edge
  // only becomes visible at the following frame_start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        shadow_en_reg[i]    <= 1'b0;
        shadow_low_x_reg[i] <= '0;
        shadow_low_y_reg[i] <= '0;
        shadow_dx_reg[i]    <= '0;
        shadow_dy_reg[i]    <= '0;
        active_en_reg[i]    <= 1'b0;
        active_low_x_reg[i] <= '0;
        active_low_y_reg[i] <= '0;
        active_dx_reg[i]    <= '0;
        active_dy_reg[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          shadow_en_reg[i]    <= cfg_en;
          shadow_low_x_reg[i] <= cfg_low_x;
          shadow_low_y_reg[i] <= cfg_low_y;
          shadow_dx_reg[i]    <= cfg_dx;
          shadow_dy_reg[i]    <= cfg_dy;
        end
        if (frame_start) begin
          active_en_reg[i]    <= shadow_en_reg[i];
          active_low_x_reg[i] <= shadow_low_x_reg[i];
          active_low_y_reg[i] <= shadow_low_y_reg[i];
          active_dx_reg[i]    <= shadow_dx_reg[i];
          active_dy_reg[i]    <= shadow_dy_reg[i];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REGIONS; gi++) begin : g_cmp
      region_cmp #(.WIDTH(WIDTH)) u_cmp (
        .en    (active_en_reg[gi]),
        .low_x (active_low_x_reg[gi]),
        .low_y (active_low_y_reg[gi]),
        .dx    (active_dx_reg[gi]),
        .dy    (active_dy_reg[gi]),
        .px_x  (px_x),
        .px_y  (px_y),
        .hit   (raw_hit[gi])
      );
    end
  endgenerate

  // Lowest-numbered hitting region wins; 0 when nothing hits.
  always_comb begin
    idx_next = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (c1_reg[i]) idx_next = IDX_W'(i);
    end
  end

  // c1 is already zero for invalid samples, so stage-2 outputs stay zero too.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_reg      <= 1'b0;
      c1_reg      <= '0;
      hit_valid   <= 1'b0;
      hit_vec     <= '0;
      hit_any     <= 1'b0;
      hit_idx     <= '0;
      sticky_hits <= '0;
    end else begin
      v1_reg      <= px_valid;
      c1_reg      <= px_valid ? raw_hit : '0;
      hit_valid   <= v1_reg;
      hit_vec     <= c1_reg;
      hit_any     <= |c1_reg;
      hit_idx     <= idx_next;
      sticky_hits <= (sticky_clear ? '0 : sticky_hits) | (hit_valid ? hit_vec : '0);
    end
  end

endmodule

// File: tb/tb_region_hit_tracker.sv
// Directed bench for region_hit_tracker: hand-computed vectors checked with
// immediate assertions two cycles after each coordinate is driven.
module tb_region_hit_tracker;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic             cfg_en;
  logic [WIDTH-1:0] cfg_low_x, cfg_low_y, cfg_dx, cfg_dy;
  logic             frame_start;
  logic             px_valid;
  logic [WIDTH-1:0] px_x, px_y;
  logic             sticky_clear;
  logic             hit_valid;
  logic [N-1:0]     hit_vec;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic [N-1:0]     sticky_hits;

  int checks = 0;
  int errors = 0;

  region_hit_tracker #(.WIDTH(WIDTH), .N_REGIONS(N)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_en       (cfg_en),
    .cfg_low_x    (cfg_low_x),
    .cfg_low_y    (cfg_low_y),
    .cfg_dx       (cfg_dx),
    .cfg_dy       (cfg_dy),
    .frame_start  (frame_start),
    .px_valid     (px_valid),
    .px_x         (px_x),
    .px_y         (px_y),
    .sticky_clear (sticky_clear),
    .hit_valid    (hit_valid),
    .hit_vec      (hit_vec),
    .hit_any      (hit_any),
    .hit_idx      (hit_idx),
    .sticky_hits  (sticky_hits)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic exp_valid,
                           input logic [N-1:0] exp_vec, input logic [IDX_W-1:0] exp_idx);
    logic exp_any;
    exp_any = |exp_vec;
    checks++;
    assert (hit_valid === exp_valid) else begin
      errors++;
      $error("FAIL %s hit_valid got %b want %b", tag, hit_valid, exp_valid);
    end
    checks++;
    assert (hit_vec === exp_vec) else begin
      errors++;
      $error("FAIL %s hit_vec got %b want %b", tag, hit_vec, exp_vec);
    end
    checks++;
    assert (hit_any === exp_any) else begin
      errors++;
      $error("FAIL %s hit_any got %b want %b", tag, hit_any, exp_any);
    end
    checks++;
    assert (hit_idx === exp_idx) else begin
      errors++;
      $error("FAIL %s hit_idx got %0d want %0d", tag, hit_idx, exp_idx);
    end
    $display("[%0t] %s valid=%b vec=%b any=%b idx=%0d sticky=%b",
             $time, tag, hit_valid, hit_vec, hit_any, hit_idx, sticky_hits);
  endtask

  task automatic check_sticky(input string tag, input logic [N-1:0] exp);
    checks++;
    assert (sticky_hits === exp) else begin
      errors++;
      $error("FAIL %s sticky_hits got %b want %b", tag, sticky_hits, exp);
    end
    $display("[%0t] %s sticky=%b", $time, tag, sticky_hits);
  endtask

  task automatic wr(input logic [IDX_W-1:0] idx, input logic en,
                    input logic [WIDTH-1:0] lx, input logic [WIDTH-1:0] ly,
                    input logic [WIDTH-1:0] dx, input logic [WIDTH-1:0] dy);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en;
    cfg_low_x = lx; cfg_low_y = ly; cfg_dx = dx; cfg_dy = dy;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Single coordinate: drive, then check exactly two edges later.
  task automatic run1(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic [N-1:0] exp_vec, input logic [IDX_W-1:0] exp_idx);
    px_valid = 1'b1; px_x = x; px_y = y;
    tick();
    px_valid = 1'b0;
    check_out({tag, "_lat1"}, 1'b0, 4'b0000, 2'd0);
    tick();
    check_out(tag, 1'b1, exp_vec, exp_idx);
  endtask

  logic [WIDTH-1:0] edge_x   [5];
  logic [WIDTH-1:0] edge_y   [5];
  logic [N-1:0]     edge_vec [5];

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_low_x = '0; cfg_low_y = '0; cfg_dx = '0; cfg_dy = '0;
    frame_start = 1'b0; px_valid = 1'b0; px_x = '0; px_y = '0; sticky_clear = 1'b0;

    tick(); tick();
    check_out("reset", 1'b0, 4'b0000, 2'd0);
    check_sticky("reset", 4'b0000);
    reset_n = 1'b1;
    tick();

    // 1: basic hit and sticky one cycle later
    wr(2'd0, 1'b1, 16'd10, 16'd20, 16'd5, 16'd5);
    frame();
    run1("t1_hit", 16'd15, 16'd25, 4'b0001, 2'd0);
    check_sticky("t1_sticky_before", 4'b0000);
    tick();
    check_sticky("t1_sticky_after", 4'b0001);
    check_out("t1_drain", 1'b0, 4'b0000, 2'd0);

    // 2: inclusive edges, back-to-back valid inputs
    edge_x[0] = 16'd10; edge_y[0] = 16'd20; edge_vec[0] = 4'b0001;
    edge_x[1] = 16'd15; edge_y[1] = 16'd25; edge_vec[1] = 4'b0001;
    edge_x[2] = 16'd9;  edge_y[2] = 16'd20; edge_vec[2] = 4'b0000;
    edge_x[3] = 16'd16; edge_y[3] = 16'd25; edge_vec[3] = 4'b0000;
    edge_x[4] = 16'd15; edge_y[4] = 16'd26; edge_vec[4] = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        px_valid = 1'b1; px_x = edge_x[i]; px_y = edge_y[i];
      end else begin
        px_valid = 1'b0;
      end
      tick();
      if (i >= 1) check_out($sformatf("t2_edge%0d", i - 1), 1'b1, edge_vec[i-1], 2'd0);
    end
    tick();
    check_out("t2_idle", 1'b0, 4'b0000, 2'd0);

    // 3: saturation, no wrap-around
    wr(2'd1, 1'b1, 16'hFFF0, 16'h0000, 16'h0020, 16'hFFFF);
    frame();
    run1("t3_sat_hit", 16'hFFFF, 16'h8000, 4'b0010, 2'd1);
    run1("t3_nowrap", 16'h0005, 16'h8000, 4'b0000, 2'd0);

    // 4: overlap priority, then disable region0; delta=0 is a single point
    wr(2'd2, 1'b1, 16'd12, 16'd22, 16'd0, 16'd0);
    frame();
    run1("t4_overlap", 16'd12, 16'd22, 4'b0101, 2'd0);
    wr(2'd0, 1'b0, 16'd10, 16'd20, 16'd5, 16'd5);
    frame();
    run1("t4_disabled", 16'd12, 16'd22, 4'b0100, 2'd2);
    run1("t4_point_miss", 16'd13, 16'd22, 4'b0000, 2'd0);

    // 5: write and frame_start on the same edge
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_en = 1'b1;
    cfg_low_x = 16'd100; cfg_low_y = 16'd100; cfg_dx = 16'd10; cfg_dy = 16'd10;
    frame_start = 1'b1;
    tick();
    cfg_we = 1'b0; frame_start = 1'b0;
    run1("t5_not_yet", 16'd105, 16'd105, 4'b0000, 2'd0);
    frame();
    run1("t5_active", 16'd105, 16'd105, 4'b1000, 2'd3);

    // 6: sticky accumulation and clear/hit collision
    tick();
    check_sticky("t6_accum_all", 4'b1111);
    sticky_clear = 1'b1;
    tick();
    sticky_clear = 1'b0;
    check_sticky("t6_cleared", 4'b0000);
    wr(2'd0, 1'b1, 16'd10, 16'd20, 16'd1, 16'd1);
    frame();
    run1("t6_r0", 16'd11, 16'd21, 4'b0001, 2'd0);
    run1("t6_r2", 16'd12, 16'd22, 4'b0100, 2'd2);
    tick();
    check_sticky("t6_sticky_0101", 4'b0101);
    run1("t6_r1", 16'hFFFF, 16'h8000, 4'b0010, 2'd1);
    sticky_clear = 1'b1;
    tick();
    sticky_clear = 1'b0;
    check_sticky("t6_clear_and_hit", 4'b0010);

    // Asynchronous reset mid-stream, between clock edges
    px_valid = 1'b1; px_x = 16'd11; px_y = 16'd21;
    tick();
    px_valid = 1'b0;
    tick();
    check_out("t6_pre_reset", 1'b1, 4'b0001, 2'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("t6_async_reset", 1'b0, 4'b0000, 2'd0);
    check_sticky("t6_async_reset", 4'b0000);
    tick();
    reset_n = 1'b1;
    tick();
    check_out("t6_post_reset", 1'b0, 4'b0000, 2'd0);
    frame();
    run1("t6_cfg_lost", 16'd11, 16'd21, 4'b0000, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
